// File: rtl/cam_types_pkg.sv
// Shared CAM key/value types and the arbiter state encoding used by the
// CAM access arbiter.
package cam_types;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } cam_arb_state_t;

endpackage

// File: rtl/cam_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo NUM_REQ (any NUM_REQ >= 2, not only powers of two).
module cam_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       any_o
);

    localparam int PW = $clog2(NUM_REQ);

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            j = int'(ptr_i) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = PW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_arbiter.sv
// Round-robin arbiter sharing one CAM between NUM_REQ requesters; serialises
// one transaction at a time: accept, single-cycle CAM op, fixed-latency wait, response.
module cam_arbiter
    import cam_types::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int READ_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_rw_n_i,
    input  key_t [NUM_REQ-1:0]       req_key_i,
    input  val_t [NUM_REQ-1:0]       req_val_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic                     rsp_hit_o,
    output val_t                     rsp_val_o,
    output logic                     cam_valid_o,
    output logic                     cam_rw_n_o,
    output key_t                     cam_key_o,
    output val_t                     cam_val_o,
    input  val_t                     cam_val_i,
    input  logic                     cam_valid_i
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    cam_arb_state_t       state_q;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        ptr_d;
    logic [PW-1:0]        gidx_q;
    logic                 rw_n_q;
    key_t                 key_q;
    val_t                 val_q;
    logic                 cam_valid_q;
    logic [CW-1:0]        cnt_q;
    logic                 hit_q;
    val_t                 data_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

    cam_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign ptr_d = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

    assign req_ready_o = (state_q == IDLE && !reset_i) ? pick_gnt : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = hit_q;
    assign rsp_val_o   = data_q;
    assign cam_valid_o = cam_valid_q;
    assign cam_rw_n_o  = rw_n_q;
    assign cam_key_o   = key_q;
    assign cam_val_o   = val_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            rw_n_q      <= 1'b0;
            key_q       <= '0;
            val_q       <= '0;
            cam_valid_q <= 1'b0;
            cnt_q       <= '0;
            hit_q       <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= '0;
        end else begin
            cam_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        gidx_q      <= pick_idx;
                        rw_n_q      <= req_rw_n_i[pick_idx];
                        key_q       <= req_key_i[pick_idx];
                        val_q       <= req_val_i[pick_idx];
                        hit_q       <= 1'b0;
                        data_q      <= '0;
                        cam_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rw_n_q) begin
                        cnt_q   <= CW'(READ_LAT - 1);
                        state_q <= WAIT;
                    end else begin
                        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
                        state_q     <= RESP;
                    end
                end
                WAIT: begin
                    // CAM result is valid exactly READ_LAT cycles after the op.
                    if (cnt_q == '0) begin
                        hit_q       <= cam_valid_i;
                        data_q      <= cam_val_i & {VAL_W{cam_valid_i}};
                        rsp_valid_q <= NUM_REQ'(1) << gidx_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
